// File: rtl/countdown_timer_bank.sv
// countdown_timer_bank: a bank of CHANNELS independent WIDTH-bit down-counters.
// Each channel can be loaded and enabled, and it pulses expire for one cycle
// after it counts down from 1. A one-shot channel stops at 0. A periodic
// channel reloads from its reload register.
//
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN
//   defined   -> periodic mode and the per-channel reload registers are built.
//   undefined -> auto_reload is ignored and every channel is one-shot.
//
// Strobe semantics (there is no back-pressure anywhere in this block):
//   load[i] is the valid bit for load_val[i]. It is accepted unconditionally
//   at the next rising edge. It wins over en[i] and over any terminal action,
//   and it never produces an expire pulse. en[i] is a level-sensitive count
//   enable.
module countdown_timer_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       auto_reload,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       zero,
  output logic [CHANNELS-1:0]       expire,
  output logic                      any_expire
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

`ifndef COUNTDOWN_AUTORELOAD_EN
  // The mode selects are not used in a one-shot-only build.
  logic unused_auto_reload;
  assign unused_auto_reload = ^auto_reload;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             expire_q;
    logic             expire_d;
    logic [WIDTH-1:0] reload_val;
    logic             periodic;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;

    // The reload register captures every load, including a load of 0.
    always_ff @(posedge clk) begin
      if (reset) begin
        reload_q <= '0;
      end else if (load[i]) begin
        reload_q <= load_val[i*WIDTH +: WIDTH];
      end
    end

    assign reload_val = reload_q;
    // A periodic channel whose reload value is 0 behaves as one-shot.
    assign periodic   = auto_reload[i] && (reload_q != '0);
`else
    assign reload_val = '0;
    assign periodic   = 1'b0;
`endif

    // Next-state logic: load first, then an enabled decrement or terminal action, else hold.
    always_comb begin
      count_d  = count_q;
      expire_d = 1'b0;
      if (load[i]) begin
        count_d = load_val[i*WIDTH +: WIDTH];
      end else if (en[i]) begin
        if (count_q == CNT_ONE) begin
          // Terminal decrement: expire in the next cycle, and stop at 0 or reload.
          expire_d = 1'b1;
          count_d  = periodic ? reload_val : '0;
        end else if (count_q == '0) begin
          // Parked at 0. A periodic channel restarts here without expiring.
          if (periodic) begin
            count_d = reload_val;
          end
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
    end

    // Count and expire registers. Reset clears both, which drops any pending pulse.
    always_ff @(posedge clk) begin
      if (reset) begin
        count_q  <= '0;
        expire_q <= 1'b0;
      end else begin
        count_q  <= count_d;
        expire_q <= expire_d;
      end
    end

    assign count[i*WIDTH +: WIDTH] = count_q;
    assign zero[i]                 = (count_q == '0);
    assign expire[i]               = expire_q;
  end

  assign any_expire = |expire;

endmodule
